// File: rtl/instr_fetch.sv
// Instruction fetch stage: PC, instruction memory address, and a
// valid/ready output register toward decode with redirect and halt.
module instr_fetch #(
  parameter int ADDR_SIZE = 32,
  parameter int INSTR_WIDTH = 32,
  parameter logic [ADDR_SIZE-1:0] RESET_PC = '0,
  parameter logic [ADDR_SIZE-1:0] PC_INCR = 4,
  parameter logic [INSTR_WIDTH-1:0] HALT_INSTR = 'h0000000D
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   fetch_en,
  output logic [ADDR_SIZE-1:0]   imem_addr,
  input  logic [INSTR_WIDTH-1:0] imem_instr,
  input  logic                   redirect,
  input  logic [ADDR_SIZE-1:0]   redirect_pc,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [INSTR_WIDTH-1:0] out_instr,
  output logic [ADDR_SIZE-1:0]   out_pc,
  output logic [ADDR_SIZE-1:0]   out_pc_next,
  output logic                   halted
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  state_t               state;
  logic [ADDR_SIZE-1:0] pc;
  logic                 load;
  logic                 is_halt;

  assign load        = !out_valid || out_ready;
  assign is_halt     = (imem_instr == HALT_INSTR);
  assign imem_addr   = pc;
  assign out_pc_next = out_pc + PC_INCR;
  assign halted      = (state == HALT);

  // PC, state and output register; redirect overrides every state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc        <= RESET_PC;
      state     <= IDLE;
      out_valid <= 1'b0;
      out_instr <= '0;
      out_pc    <= '0;
    end else if (redirect) begin
      pc        <= redirect_pc;
      out_valid <= 1'b0;
      state     <= RUN;
    end else begin
      unique case (state)
        IDLE: begin
          if (fetch_en) state <= RUN;
        end
        RUN: begin
          if (load) begin
            out_valid <= 1'b1;
            out_instr <= imem_instr;
            out_pc    <= pc;
            if (is_halt) state <= HALT;
            else         pc    <= pc + PC_INCR;
          end
        end
        HALT: begin
          if (out_ready) out_valid <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
